// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit_if
//  Description : Control/target bus between decode/ALU logic and the PC unit.
//                master = decode side, slave = pc_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             pc_en;
    logic             comp;
    logic             b;
    logic             jal;
    logic             jalr;
    logic             mret;
    logic             trap_req;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  imm_j;
    logic [XLEN-1:0]  imm_b;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic             fetch_valid;
    logic [XLEN-1:0]  mepc;
    logic [3:0]       mcause;
    logic [CNT_W-1:0] instret;

    modport master (
        output pc_en, comp, b, jal, jalr, mret, trap_req, rd1, imm_i, imm_j, imm_b,
        input  pc, pc_plus4, fetch_valid, mepc, mcause, instret
    );

    modport slave (
        input  pc_en, comp, b, jal, jalr, mret, trap_req, rd1, imm_i, imm_j, imm_b,
        output pc, pc_plus4, fetch_valid, mepc, mcause, instret
    );
endinterface
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Program-counter unit: sequential/branch/JAL/JALR/MRET flow,
//                trap entry (external and target-misaligned), one-cycle
//                redirect bubble and retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h0000_0100,
    parameter int              CNT_W        = 32
) (
    input  wire         clk,
    input  wire         rst,
    pc_unit_if.slave    bus
);
    localparam logic [XLEN-1:0]  c_FOUR       = XLEN'(4);
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);
    localparam logic [3:0]       c_CAUSE_MISA = 4'd0;
    localparam logic [3:0]       c_CAUSE_TRAP = 4'd2;

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_BUBBLE = 2'd2
    } state_t;

    state_t           r_state;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_mepc;
    logic [3:0]       r_mcause;
    logic [CNT_W-1:0] r_instret;
    logic             r_fetch_valid;

    logic [XLEN-1:0]  w_seq;
    logic [XLEN-1:0]  w_jr_sum;
    logic [XLEN-1:0]  w_target;
    logic             w_redirect;
    logic             w_misaligned;

    assign w_seq    = r_pc + c_FOUR;
    assign w_jr_sum = bus.rd1 + bus.imm_i;

    // Pick the redirect target by priority; trap_req is handled ahead of this.
    always_comb begin
        w_redirect = 1'b1;
        w_target   = w_seq;
        if (bus.mret) begin
            w_target = r_mepc;
        end else if (bus.jalr) begin
            w_target = {w_jr_sum[XLEN-1:1], 1'b0};
        end else if (bus.jal) begin
            w_target = r_pc + bus.imm_j;
        end else if (bus.b && bus.comp) begin
            w_target = r_pc + bus.imm_b;
        end else begin
            w_redirect = 1'b0;
        end
    end

    // Bit0 is always clear for JALR; bit1 set means a non-word-aligned target.
    assign w_misaligned = w_redirect && w_target[1];

    // PC state machine, trap CSRs and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_VECTOR;
            r_mepc        <= '0;
            r_mcause      <= '0;
            r_instret     <= '0;
            r_fetch_valid <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT, S_BUBBLE: begin
                    r_state       <= S_RUN;
                    r_fetch_valid <= 1'b1;
                end
                S_RUN: begin
                    if (bus.pc_en) begin
                        if (bus.trap_req || w_misaligned) begin
                            // Trapping instruction does not retire; target never loaded.
                            r_mepc        <= r_pc;
                            r_mcause      <= bus.trap_req ? c_CAUSE_TRAP : c_CAUSE_MISA;
                            r_pc          <= TRAP_VECTOR;
                            r_state       <= S_BUBBLE;
                            r_fetch_valid <= 1'b0;
                        end else if (w_redirect) begin
                            r_pc          <= w_target;
                            r_instret     <= r_instret + c_ONE;
                            r_state       <= S_BUBBLE;
                            r_fetch_valid <= 1'b0;
                        end else begin
                            r_pc          <= w_seq;
                            r_instret     <= r_instret + c_ONE;
                        end
                    end
                end
                default: begin
                    r_state       <= S_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = w_seq;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.mepc        = r_mepc;
    assign bus.mcause      = r_mcause;
    assign bus.instret     = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Directed self-checking bench for pc_unit (32-bit default
//                instance plus a 64-bit / 8-bit-counter instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(32), .CNT_W(32)) bus_a ();
    pc_unit_if #(.XLEN(64), .CNT_W(8))  bus_b ();

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100), .CNT_W(32)
    ) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    pc_unit #(
        .XLEN(64), .RESET_VECTOR(64'h0), .TRAP_VECTOR(64'h100), .CNT_W(8)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        bus_a.pc_en = 1'b1; bus_a.comp = 1'b0; bus_a.b = 1'b0; bus_a.jal = 1'b0;
        bus_a.jalr = 1'b0; bus_a.mret = 1'b0; bus_a.trap_req = 1'b0;
        bus_a.rd1 = '0; bus_a.imm_i = '0; bus_a.imm_j = '0; bus_a.imm_b = '0;
    endtask

    task automatic clear_b();
        bus_b.pc_en = 1'b1; bus_b.comp = 1'b0; bus_b.b = 1'b0; bus_b.jal = 1'b0;
        bus_b.jalr = 1'b0; bus_b.mret = 1'b0; bus_b.trap_req = 1'b0;
        bus_b.rd1 = '0; bus_b.imm_i = '0; bus_b.imm_j = '0; bus_b.imm_b = '0;
    endtask

    // Absolute jump through JALR then wait out the bubble.
    task automatic goto_a(input logic [31:0] target);
        bus_a.jalr = 1'b1; bus_a.rd1 = target; bus_a.imm_i = '0;
        step();
        clear_a();
        step();
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        clear_a();
        clear_b();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",      64'(bus_a.pc), 64'h0);
        check("rst_fv",      64'(bus_a.fetch_valid), 64'h0);
        check("rst_instret", 64'(bus_a.instret), 64'h0);
        check("rst_mepc",    64'(bus_a.mepc), 64'h0);
        check("rst_mcause",  64'(bus_a.mcause), 64'h0);

        // Reset release: BOOT, then RUN, then sequential fetch.
        rst_a = 1'b0;
        #2;
        check("boot_fv", 64'(bus_a.fetch_valid), 64'h0);
        step();
        check("run_fv", 64'(bus_a.fetch_valid), 64'h1);
        check("run_pc0", 64'(bus_a.pc), 64'h0);
        step();
        check("seq_pc4", 64'(bus_a.pc), 64'h4);
        step();
        check("seq_pc8", 64'(bus_a.pc), 64'h8);
        check("seq_instret2", 64'(bus_a.instret), 64'h2);
        check("pc_plus4", 64'(bus_a.pc_plus4), 64'hC);

        // Taken branch from 0x20 by -8.
        goto_a(32'h20);
        check("goto20_pc", 64'(bus_a.pc), 64'h20);
        check("goto20_instret", 64'(bus_a.instret), 64'h3);
        bus_a.b = 1'b1; bus_a.comp = 1'b1; bus_a.imm_b = 32'hFFFF_FFF8;
        step();
        check("br_taken_pc", 64'(bus_a.pc), 64'h18);
        check("br_taken_bubble", 64'(bus_a.fetch_valid), 64'h0);
        check("br_taken_instret", 64'(bus_a.instret), 64'h4);
        clear_a();
        step();
        check("br_taken_fv", 64'(bus_a.fetch_valid), 64'h1);

        // Not-taken branch: sequential, no bubble.
        goto_a(32'h20);
        bus_a.b = 1'b1; bus_a.comp = 1'b0; bus_a.imm_b = 32'hFFFF_FFF8;
        step();
        check("br_nt_pc", 64'(bus_a.pc), 64'h24);
        check("br_nt_fv", 64'(bus_a.fetch_valid), 64'h1);
        check("br_nt_instret", 64'(bus_a.instret), 64'h6);
        clear_a();

        // JALR to 0x103 -> 0x102, bit1 set -> misaligned trap.
        goto_a(32'h20);
        bus_a.jalr = 1'b1; bus_a.rd1 = 32'h103; bus_a.imm_i = 32'h0;
        step();
        check("misa_pc", 64'(bus_a.pc), 64'h100);
        check("misa_mepc", 64'(bus_a.mepc), 64'h20);
        check("misa_mcause", 64'(bus_a.mcause), 64'h0);
        check("misa_instret", 64'(bus_a.instret), 64'h7);
        check("misa_fv", 64'(bus_a.fetch_valid), 64'h0);
        clear_a();
        step();

        // JALR 0x201+3 -> 0x204, aligned.
        bus_a.jalr = 1'b1; bus_a.rd1 = 32'h201; bus_a.imm_i = 32'h3;
        step();
        check("jalr_pc", 64'(bus_a.pc), 64'h204);
        check("jalr_instret", 64'(bus_a.instret), 64'h8);
        clear_a();
        step();

        // trap_req beats jal; then mret returns to 0x40.
        goto_a(32'h40);
        bus_a.trap_req = 1'b1; bus_a.jal = 1'b1; bus_a.imm_j = 32'h8;
        step();
        check("trap_pc", 64'(bus_a.pc), 64'h100);
        check("trap_mepc", 64'(bus_a.mepc), 64'h40);
        check("trap_mcause", 64'(bus_a.mcause), 64'h2);
        check("trap_instret", 64'(bus_a.instret), 64'h9);
        clear_a();
        step();
        bus_a.mret = 1'b1;
        step();
        check("mret_pc", 64'(bus_a.pc), 64'h40);
        check("mret_bubble", 64'(bus_a.fetch_valid), 64'h0);
        check("mret_mcause", 64'(bus_a.mcause), 64'h2);
        clear_a();
        step();
        check("mret_fv", 64'(bus_a.fetch_valid), 64'h1);

        // Stall at 0x10 for three cycles, with a JAL pending.
        goto_a(32'h10);
        bus_a.pc_en = 1'b0; bus_a.jal = 1'b1; bus_a.imm_j = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", 64'(bus_a.pc), 64'h10);
            check("stall_instret", 64'(bus_a.instret), 64'hB);
            check("stall_fv", 64'(bus_a.fetch_valid), 64'h1);
        end
        clear_a();
        step();
        check("unstall_pc", 64'(bus_a.pc), 64'h14);
        check("unstall_instret", 64'(bus_a.instret), 64'hC);

        // Async reset in the middle of a bubble cycle.
        bus_a.jalr = 1'b1; bus_a.rd1 = 32'h80;
        step();
        clear_a();
        check("pre_arst_pc", 64'(bus_a.pc), 64'h80);
        #2;
        rst_a = 1'b1;
        #1;
        check("arst_pc", 64'(bus_a.pc), 64'h0);
        check("arst_fv", 64'(bus_a.fetch_valid), 64'h0);
        check("arst_instret", 64'(bus_a.instret), 64'h0);
        check("arst_mepc", 64'(bus_a.mepc), 64'h0);

        // 64-bit PC, 8-bit counter: wrap 255 -> 0.
        @(negedge clk);
        rst_b = 1'b0;
        step();
        check("b_run_fv", 64'(bus_b.fetch_valid), 64'h1);
        repeat (255) step();
        check("b_instret255", 64'(bus_b.instret), 64'hFF);
        check("b_pc255", bus_b.pc, 64'h3FC);
        step();
        check("b_instret_wrap", 64'(bus_b.instret), 64'h0);
        check("b_pc256", bus_b.pc, 64'h400);
        bus_b.jalr = 1'b1; bus_b.rd1 = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        clear_b();
        check("b_jalr_hi", bus_b.pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        step();
        check("b_pc_wrap", bus_b.pc, 64'h0);
        check("b_instret2", 64'(bus_b.instret), 64'h2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the RISC-V core. Successor to the fixed 32-bit PC counter.
- Computes next PC for sequential, branch, JAL and JALR flow, plus external trap entry and MRET return.
- Adds target-misalignment detection, a one-cycle redirect bubble FSM and a retired-instruction counter.
- Sits between decode/ALU compare logic and instruction memory address port.

Parameters:
- XLEN, 32, width of PC, operands and immediates
- RESET_VECTOR, 32'h0000_0000, PC value loaded at reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry (low 2 bits must be 0)
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- pc_en  in  1  advance enable; 0 = stall, all state held
- comp  in  1  branch condition from ALU compare
- b  in  1  current instruction is a conditional branch
- jal  in  1  current instruction is JAL
- jalr  in  1  current instruction is JALR
- mret  in  1  current instruction is MRET
- trap_req  in  1  external/illegal-instruction trap request
- rd1  in  XLEN  rs1 value for JALR
- imm_i  in  XLEN  sign-extended I-immediate
- imm_j  in  XLEN  sign-extended J-immediate
- imm_b  in  XLEN  sign-extended B-immediate
- pc  out  XLEN  current PC (fetch address)
- pc_plus4  out  XLEN  pc+4, link value for JAL/JALR
- fetch_valid  out  1  instruction at pc is valid for execution
- mepc  out  XLEN  saved exception PC
- mcause  out  4  0 = instruction-address-misaligned, 2 = trap_req, others unused
- instret  out  CNT_W  count of retired instructions

Behaviour:
- Reset (async, immediate): pc=RESET_VECTOR, mepc=0, mcause=0, instret=0, fetch_valid=0, state=BOOT.
- FSM states:
  - BOOT: fetch_valid=0; next edge -> RUN, pc unchanged.
  - RUN: fetch_valid=1.
  - BUBBLE: fetch_valid=0; next edge -> RUN, pc unchanged.
- pc_en only qualifies RUN-state updates. BOOT and BUBBLE advance regardless of pc_en.
- Target computation, all XLEN-bit, wrap modulo 2^XLEN:
  - seq = pc+4
  - br = pc+imm_b
  - j = pc+imm_j
  - jr = (rd1+imm_i) with bit0 cleared
- Selection in RUN with pc_en=1, highest priority first:
  1. trap_req
  2. mret
  3. jalr
  4. jal
  5. b & comp
  6. sequential
- b with comp=0 takes the sequential path.
- Trap entry:
  - On trap_req: mepc<=pc, mcause<=2, pc<=TRAP_VECTOR, state<=BUBBLE.
  - If the selected redirect target has bit1 set: same trap entry but mcause<=0, mepc<=pc. The target is never loaded.
- Redirect (mret, jalr, jal, taken branch) with aligned target: pc<=target, state<=BUBBLE.
- mret: pc<=mepc. mepc/mcause unchanged.
- Sequential: pc<=pc+4, state stays RUN.
- instret increments by 1 on every RUN edge with pc_en=1 and no trap (trap_req or misaligned). Wraps at 2^CNT_W.
- pc_en=0 in RUN: pc, mepc, mcause, instret, state held; fetch_valid stays 1.
- Simultaneous control flags (e.g. jal & b) are resolved by the priority list; no error is raised.
- Reset asserted mid-BUBBLE or mid-stall returns to BOOT immediately.

Test Plan:
- Reset release: rst 1->0, pc_en=1, no flags -> BOOT: pc=0, fetch_valid=0; next cycle fetch_valid=1; then pc 0x0,0x4,0x8; instret=2 after two RUN edges.
- Taken/not-taken branch:
  - pc=0x20, b=1, comp=1, imm_b=-8 -> pc=0x18, one bubble cycle (fetch_valid=0), instret +1.
  - Same with comp=0 -> pc=0x24, no bubble.
- JALR alignment:
  - rd1=0x103, imm_i=0 -> pc=0x102 masked to bit0=0; bit1 set -> misaligned trap: pc=0x100, mepc=0x20, mcause=0, instret unchanged.
  - rd1=0x201, imm_i=3 -> pc=0x204, no trap.
- Priority: trap_req=1 with jal=1 at pc=0x40 -> pc=TRAP_VECTOR, mepc=0x40, mcause=2. Then mret=1 -> pc=0x40 after one bubble.
- Stall: pc_en=0 for 3 cycles at pc=0x10 -> pc, instret constant; pc_en=1 -> pc=0x14.
- Async reset: assert rst mid-clock during BUBBLE -> pc=RESET_VECTOR and fetch_valid=0 before the next edge. Repeat with XLEN=64, CNT_W=8: instret wraps 255->0.
